// File: rtl/gemv_requant_if.sv
// Output element stream from gemv_requant toward the activation buffer.
interface gemv_requant_if #(
  parameter int OUT_WIDTH = 8,
  parameter int IDX_WIDTH = 7
);
  logic signed [OUT_WIDTH-1:0] out_data;
  logic        [IDX_WIDTH-1:0] out_idx;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;

  modport master (
    output out_data, out_idx, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_idx, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/gemv_requant.sv
// Snapshots the GEMV result vector on start, then streams requantized
// (multiply, round-half-up shift, saturate, optional ReLU) elements one per cycle.
module gemv_requant #(
  parameter int DATA_WIDTH  = 8,
  parameter int ROWS        = 128,
  parameter int MULT_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int OUT_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] y_in [ROWS],
  input  logic        [MULT_WIDTH-1:0] scale_mult,
  input  logic       [SHIFT_WIDTH-1:0] scale_shift,
  input  logic                         relu_en,
  gemv_requant_if.master               out_s,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = $clog2(ROWS);
  localparam int CNT_W = IDX_W + 1;
  localparam int PW    = DATA_WIDTH + MULT_WIDTH + 1;
  // Headroom for the rounding constant at the largest shift amount.
  localparam int EW    = PW + 2**SHIFT_WIDTH;

  localparam logic signed [EW-1:0] MAXV = (EW'(1) <<< (OUT_WIDTH - 1)) - EW'(1);
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0]  ybuf [ROWS];
  logic        [MULT_WIDTH-1:0]  mult_q;
  logic        [SHIFT_WIDTH-1:0] shift_q;
  logic                          relu_q;
  logic        [CNT_W-1:0]       rd_idx;

  logic signed [OUT_WIDTH-1:0] data_q;
  logic        [IDX_W-1:0]     idx_q;
  logic                        valid_q;
  logic                        last_q;

  logic accept;
  logic load;

  logic signed [EW-1:0]        v_ext, m_ext, prod, rnd, shifted;
  logic signed [OUT_WIDTH-1:0] f_res;

  assign accept = valid_q & out_s.out_ready;
  assign load   = (state_q == RUN) && (!valid_q || out_s.out_ready) &&
                  (rd_idx < CNT_W'(ROWS));

  always_comb begin
    v_ext   = EW'(ybuf[rd_idx[IDX_W-1:0]]);
    m_ext   = EW'({1'b0, mult_q});
    prod    = v_ext * m_ext;
    rnd     = '0;
    if (shift_q != '0) rnd[shift_q - 1'b1] = 1'b1;
    shifted = (prod + rnd) >>> shift_q;
    if (shifted > MAXV)      f_res = MAXV[OUT_WIDTH-1:0];
    else if (shifted < MINV) f_res = MINV[OUT_WIDTH-1:0];
    else                     f_res = shifted[OUT_WIDTH-1:0];
    if (relu_q && f_res[OUT_WIDTH-1]) f_res = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROWS; i++) ybuf[i] <= '0;
      mult_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      rd_idx  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ybuf    <= y_in;
            mult_q  <= scale_mult;
            shift_q <= scale_shift;
            relu_q  <= relu_en;
            rd_idx  <= '0;
          end
        end
        RUN: begin
          if (load) begin
            data_q  <= f_res;
            idx_q   <= rd_idx[IDX_W-1:0];
            last_q  <= (rd_idx == CNT_W'(ROWS - 1));
            valid_q <= 1'b1;
            rd_idx  <= rd_idx + 1'b1;
          end else if (accept) begin
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_s.out_data  = data_q;
  assign out_s.out_idx   = idx_q;
  assign out_s.out_valid = valid_q;
  assign out_s.out_last  = last_q;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_gemv_requant.sv
// Directed bench for gemv_requant with ROWS=4; expected values hand-computed.
module tb_gemv_requant;
  localparam int ROWS = 4;

  typedef logic signed [7:0] vec_t [ROWS];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  vec_t        y_in;
  logic [15:0] scale_mult;
  logic [4:0]  scale_shift;
  logic        relu_en;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  gemv_requant_if #(.OUT_WIDTH(8), .IDX_WIDTH(2)) s_if ();

  gemv_requant #(
    .DATA_WIDTH (8),
    .ROWS       (ROWS),
    .MULT_WIDTH (16),
    .SHIFT_WIDTH(5),
    .OUT_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .y_in       (y_in),
    .scale_mult (scale_mult),
    .scale_shift(scale_shift),
    .relu_en    (relu_en),
    .out_s      (s_if.master),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  vec_t basic_y, basic_e;

  // One full pass with out_ready held high; start is driven in cycle 0.
  task automatic run_pass(input string name, input vec_t y, input logic [15:0] m,
                          input logic [4:0] s, input logic r, input vec_t e);
    int k;
    logic exp_last;
    @(negedge clk);
    y_in = y; scale_mult = m; scale_shift = s; relu_en = r;
    s_if.out_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= ROWS + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c >= 2 && c <= ROWS + 1) begin
        k = c - 2;
        exp_last = (k == ROWS - 1);
        n_checks++;
        if (s_if.out_valid !== 1'b1) begin
          n_fail++; $display("FAIL %s valid c%0d: got %b expected 1", name, c, s_if.out_valid);
        end
        n_checks++;
        if (s_if.out_data !== e[k]) begin
          n_fail++; $display("FAIL %s data[%0d]: got %0d expected %0d", name, k, s_if.out_data, e[k]);
        end
        n_checks++;
        if (s_if.out_idx !== 2'(k)) begin
          n_fail++; $display("FAIL %s idx c%0d: got %0d expected %0d", name, c, s_if.out_idx, k);
        end
        n_checks++;
        if (s_if.out_last !== exp_last) begin
          n_fail++; $display("FAIL %s last c%0d: got %b expected %b", name, c, s_if.out_last, exp_last);
        end
      end else begin
        n_checks++;
        if (s_if.out_valid !== 1'b0) begin
          n_fail++; $display("FAIL %s valid c%0d: got %b expected 0", name, c, s_if.out_valid);
        end
      end
      n_checks++;
      if (done !== (c == ROWS + 2)) begin
        n_fail++; $display("FAIL %s done c%0d: got %b expected %b", name, c, done, (c == ROWS + 2));
      end
      n_checks++;
      if (busy !== (c <= ROWS + 2)) begin
        n_fail++; $display("FAIL %s busy c%0d: got %b expected %b", name, c, busy, (c <= ROWS + 2));
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if (s_if.out_valid !== 1'b0 || s_if.out_data !== 8'sd0 || s_if.out_idx !== 2'd0 ||
        s_if.out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got valid=%b data=%0d idx=%0d last=%b busy=%b done=%b expected all 0",
               name, s_if.out_valid, s_if.out_data, s_if.out_idx, s_if.out_last, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s_if.out_ready = 1'b1;
    y_in = '{default: 8'sd0}; scale_mult = '0; scale_shift = '0; relu_en = 1'b0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_pass("basic", basic_y, 16'd3, 5'd2, 1'b0, basic_e);
  endtask

  task automatic test_rounding_relu();
    vec_t y, e0, e1;
    y  = '{8'sd5, -8'sd5, 8'sh80, 8'sd7};
    e0 = '{8'sd3, -8'sd2, -8'sd64, 8'sd4};
    e1 = '{8'sd3, 8'sd0, 8'sd0, 8'sd4};
    run_pass("round", y, 16'd1, 5'd1, 1'b0, e0);
    run_pass("relu", y, 16'd1, 5'd1, 1'b1, e1);
  endtask

  task automatic test_saturation();
    vec_t y, e;
    y = '{8'sd127, 8'sh80, 8'sd64, -8'sd64};
    e = '{8'sd127, 8'sh80, 8'sd127, 8'sh80};
    run_pass("saturate", y, 16'd4, 5'd0, 1'b0, e);
  endtask

  task automatic test_max_shift();
    vec_t y, e;
    y = '{8'sh80, 8'sd127, 8'sd1, -8'sd1};
    e = '{8'sd0, 8'sd0, 8'sd0, 8'sd0};
    run_pass("maxshift", y, 16'hFFFF, 5'd31, 1'b0, e);
  endtask

  task automatic test_backpressure();
    int k;
    @(negedge clk);
    y_in = basic_y; scale_mult = 16'd3; scale_shift = 5'd2; relu_en = 1'b0;
    s_if.out_ready = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c >= 2 && c <= 9) begin
        k = (c <= 6) ? 0 : c - 6;
        n_checks++;
        if (s_if.out_valid !== 1'b1 || s_if.out_data !== basic_e[k] || s_if.out_idx !== 2'(k)) begin
          n_fail++;
          $display("FAIL bp elem c%0d: got valid=%b data=%0d idx=%0d expected 1/%0d/%0d",
                   c, s_if.out_valid, s_if.out_data, s_if.out_idx, basic_e[k], k);
        end
      end else begin
        n_checks++;
        if (s_if.out_valid !== 1'b0) begin
          n_fail++; $display("FAIL bp valid c%0d: got %b expected 0", c, s_if.out_valid);
        end
      end
      n_checks++;
      if (done !== (c == 10)) begin
        n_fail++; $display("FAIL bp done c%0d: got %b expected %b", c, done, (c == 10));
      end
      if (c == 6) s_if.out_ready = 1'b1;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL bp busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_snapshot();
    int dones = 0;
    @(negedge clk);
    y_in = basic_y; scale_mult = 16'd3; scale_shift = 5'd2; relu_en = 1'b0;
    s_if.out_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = (c == 3);
      if (c == 1) begin
        y_in = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        scale_mult = 16'd7; scale_shift = 5'd0; relu_en = 1'b1;
      end
      if (done) dones++;
      if (c >= 2 && c <= 5) begin
        n_checks++;
        if (s_if.out_valid !== 1'b1 || s_if.out_data !== basic_e[c-2]) begin
          n_fail++;
          $display("FAIL snap data c%0d: got valid=%b data=%0d expected 1/%0d",
                   c, s_if.out_valid, s_if.out_data, basic_e[c-2]);
        end
      end
      if (c >= 7) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL snap busy c%0d: got %b expected 0", c, busy);
        end
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL snap done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk);
    y_in = basic_y; scale_mult = 16'd3; scale_shift = 5'd2; relu_en = 1'b0;
    s_if.out_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dones++;
      n_checks++;
      if (busy !== 1'b0 || s_if.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid idle c%0d: got busy=%b valid=%b expected 0/0", c, busy, s_if.out_valid);
      end
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL rst_mid done_count: got %0d expected 0", dones);
    end
    run_pass("after_rst", basic_y, 16'd3, 5'd2, 1'b0, basic_e);
  endtask

  initial begin
    basic_y = '{8'sd100, -8'sd50, 8'sd0, 8'sd1};
    basic_e = '{8'sd75, -8'sd37, 8'sd0, 8'sd1};
    test_reset();
    test_basic();
    test_rounding_relu();
    test_saturation();
    test_max_shift();
    test_backpressure();
    test_snapshot();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gemv_requant.md
# gemv_requant

Output stage that sits directly downstream of the GEMV engine. On the engine's one-cycle `done` pulse it snapshots the full `y` vector. It then requantizes each signed accumulator value using a fixed-point multiply, a rounding right shift and saturation, and optionally applies ReLU. Results leave one element per cycle on a valid/ready stream toward the activation buffer, and the block frees the GEMV outputs immediately for the next layer.

## Interface
- `DATA_WIDTH`, 8: width of each input element from GEMV; two's complement.
- `ROWS`, 128: vector length; must be ≥2.
- `MULT_WIDTH`, 16: width of the unsigned scale multiplier.
- `SHIFT_WIDTH`, 5: width of the right-shift amount.
- `OUT_WIDTH`, 8: width of each output element; two's complement.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  capture strobe; connects to GEMV `done`.
- `y_in[0:ROWS-1]`  in  DATA_WIDTH each  GEMV result vector; sampled only on the accepted start edge.
- `scale_mult`  in  MULT_WIDTH  unsigned multiplier; latched with start.
- `scale_shift`  in  SHIFT_WIDTH  rounding right-shift amount; latched with start.
- `relu_en`  in  1  clamp negatives to 0; latched with start.
- `out_data`  out  OUT_WIDTH  requantized element.
- `out_idx`  out  $clog2(ROWS)  row index of `out_data`.
- `out_valid`  out  1  `out_data`, `out_idx` and `out_last` are valid.
- `out_ready`  in  1  consumer accepts the element this cycle.
- `out_last`  out  1  high with the element at index ROWS-1.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last element is accepted.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - On an edge with `start`=1, latch `y_in[*]` into an internal buffer and latch `scale_mult`, `scale_shift` and `relu_en`.
  - Set `rd_idx` to 0 and go to RUN.
  - `start` is ignored in RUN and DONE; there is no queuing.
- **RUN**
  - The output register loads when it is empty or is being accepted in the current cycle (`out_valid & out_ready`), provided `rd_idx` < ROWS.
  - A load sets `out_data` to f(buf[rd_idx]), `out_idx` to `rd_idx`, `out_last` to (`rd_idx`==ROWS-1) and `out_valid` to 1, and increments `rd_idx`.
  - On an accept with no element left to load, `out_valid` goes to 0.
  - An accept with `out_last`=1 moves the FSM to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- **Arithmetic f(v)**
  - Compute p = signed(v) × zero-extended `scale_mult`, at full width DATA_WIDTH+MULT_WIDTH+1.
  - If s=`scale_shift` > 0: p = p + 2^(s-1). Then arithmetic shift: r = p >>> s. This is round-half-up.
  - Saturate r to the range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - If `relu_en`=1 and r < 0, then r = 0.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_idx` and `out_last` hold stable.
- Changing `y_in` or the scale inputs after the capture edge has no effect on the current pass.

## Timing
- Reset values: `out_data`=0, `out_idx`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, FSM in IDLE, buffer contents 0.
- Reset during RUN or DONE aborts the pass immediately, including the element in flight; no `done` is produced.
- With `start` high in cycle 0 and `out_ready` held at 1:
  - `busy` is high from cycle 1.
  - Element k is valid in cycle 2+k.
  - `out_last` is high in cycle ROWS+1.
  - `done` is high in cycle ROWS+2.
  - The FSM is in IDLE again in cycle ROWS+3, and the next `start` can be accepted there.
- Throughput is 1 element per cycle, with no bubble between elements while `out_ready`=1.
- `out_valid` does not depend combinationally on `out_ready`.

## Test plan
All scenarios use ROWS=4.
- **Basic scaling:** y={100,-50,0,1}, mult=3, shift=2, relu=0, ready=1 → out {75,-37,0,1}, idx 0..3, `out_last` only on idx 3, `done` in cycle 6.
- **Rounding and ReLU:** y={5,-5,-128,7}, mult=1, shift=1.
  - relu=0 → {3,-2,-64,4}.
  - Repeat with relu=1 → {3,0,0,4}.
- **Saturation:** y={127,-128,64,-64}, mult=4, shift=0 → {127,-128,127,-128}.
- **Backpressure:** `out_ready` low for cycles 2–5, then high → element 0 is held stable with `out_valid`=1 throughout the stall, then all 4 elements are delivered in order with no duplicates and `done` in cycle 10.
- **Snapshot and ignored start:** change `y_in`, then pulse `start` in cycle 3 during RUN → output reflects only the original capture, and exactly one `done` is produced.
- **Reset mid-operation:** assert `rst` in cycle 3 → all outputs are 0 immediately. A fresh `start` after release gives a full correct 4-element pass.
